multi_cycle_processor: RTL and testbench
========================================

MULTI_CYCLE_PROCESSOR -- requirements
Module: multi_cycle_processor

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register, ALU and data-memory word width.
REQ-002 SHALL have parameter PC_W, default 5, meaning program-counter and instruction-address width.
REQ-003 SHALL have parameter DADDR_W, default 5, meaning data-memory address width.
REQ-004 SHALL have parameter NREG, default 32, meaning register count; register 0 reads as zero.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  in  1  meaning reset, asynchronous, active-high.
REQ-007 SHALL have port imem_req  out  1  meaning instruction fetch request.
REQ-008 SHALL have port imem_addr  out  PC_W  meaning fetch address, equal to pc.
REQ-009 SHALL have port imem_ready  in  1  meaning imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata  in  32  meaning fetched instruction.
REQ-011 SHALL have port dmem_req  out  1  meaning data access request.
REQ-012 SHALL have port dmem_we  out  1  meaning 1 = store, 0 = load.
REQ-013 SHALL have ports dmem_addr  out  DADDR_W, dmem_wdata  out  DATA_W, and dmem_rdata  in  DATA_W, meaning data address, store data and load data.
REQ-014 SHALL have port dmem_ready  in  1  meaning access complete; dmem_rdata valid for loads.
REQ-015 SHALL have port halted  out  1  meaning HALT executed and core stopped.

Function
REQ-016 SHALL decode opcode [31:28], rd [23:16], rs1 [15:8], rs2/imm [7:0]; only the low log2(NREG) bits of register fields are used.
REQ-017 SHALL implement opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LOAD, 5 STORE, 6 BEQ, 15 HALT; all others execute as NOP.
REQ-018 SHALL sequence states FETCH -> DECODE -> EXEC -> (MEM for LOAD/STORE) -> WB -> FETCH; HALT enters state HALTED.
REQ-019 SHALL hold imem_req high in FETCH until the imem_ready cycle, latch imem_rdata into the instruction register, then advance; imem_addr stays stable while requesting.
REQ-020 SHALL, in MEM, hold dmem_req and stable dmem_addr/dmem_we/dmem_wdata until the dmem_ready cycle; LOAD latches dmem_rdata at that edge.
REQ-021 SHALL compute ALU results modulo 2^DATA_W; SUB wraps with no flags exported.
REQ-022 SHALL use LOAD address r[rs1] + imm and STORE address r[rs1] + imm, both truncated to DADDR_W; STORE writes r[rd].
REQ-023 SHALL, for BEQ, set pc = pc + sign-extended imm when r[rd] == r[rs1], else pc + 1; pc arithmetic wraps modulo 2^PC_W.
REQ-024 SHALL update pc in WB only; non-branch instructions increment pc by 1.
REQ-025 SHALL write rd in WB for ADD/SUB/AND/OR/LOAD; writes to register 0 are discarded.
REQ-026 SHALL give ALU and branch instructions a 4-cycle latency and LOAD/STORE a 5-cycle latency with zero-wait memories; each wait cycle adds 1.
REQ-027 SHALL, in HALTED, assert halted, hold all requests low, and remain there until rst.
REQ-028 SHALL drive dmem_req and imem_req low in every state except MEM and FETCH respectively.

Reset
REQ-029 SHALL, while rst is high, set pc = 0, state = FETCH, all registers = 0, and imem_req/dmem_req/dmem_we/halted = 0.
REQ-030 SHALL abandon any in-flight access on rst, with no register or pc update; fetch from address 0 begins in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place opcode constants, field bit positions and the state enumeration in shared package proc_pkg.
REQ-032 SHALL instantiate register file sub-module reg_file (parameters DATA_W and NREG, two read ports, one write port, register 0 hardwired to zero).

Verification
REQ-033 Bench SHALL run ADD r1=r2+r3 with r2=5 and r3=7 -> r1=12, with WB 4 cycles after the first FETCH (zero-wait).
REQ-034 Bench SHALL run SUB with 3-10, DATA_W=8 -> result 0xF9.
REQ-035 Bench SHALL run STORE of 0xAB to address 4, then LOAD with dmem_ready delayed 3 cycles -> rd=0xAB, request held stable for 4 cycles.
REQ-036 Bench SHALL run BEQ at pc=3 with imm=0xFE and equal operands -> next fetch at pc 1; with unequal operands -> next fetch at pc 4.
REQ-037 Bench SHALL write to r0 and then read r0 -> r0 = 0; HALT -> halted=1 with no further imem_req.
REQ-038 Bench SHALL assert rst during a MEM wait -> dmem_req drops immediately, pc=0, and a fetch from 0 follows rst deassertion.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode, field and state definitions for the multi-cycle core.
package proc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RD_LSB  = 16;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned FIELD_W = 8;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  // Opcodes that need the data-memory phase.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Opcodes that write rd in the write-back phase.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Two-read, one-write register file; register 0 always reads as zero.
module reg_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  raddr_a,
  input  logic [$clog2(NREG)-1:0]  raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata
);

  logic [DATA_W-1:0] regs [NREG];

  // Register storage; writes to register 0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multi_cycle_processor.sv
// Multi-cycle core: FETCH -> DECODE -> EXEC -> (MEM) -> WB, with HALT stop.
module multi_cycle_processor
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PC_W    = 5,
  parameter int unsigned DADDR_W = 5,
  parameter int unsigned NREG    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic               halted
);

  localparam int unsigned RA_W = $clog2(NREG);

  state_t               state, state_next;
  logic [INSTR_W-1:0]   ir;
  logic [PC_W-1:0]      pc;
  logic [DATA_W-1:0]    op_a, op_b, res, alu;
  logic [DADDR_W-1:0]   maddr;
  logic                 take;

  logic [3:0]           opc;
  logic [RA_W-1:0]      rd_f, rs1_f, rs2_f, rf_raddr_b;
  logic [FIELD_W-1:0]   imm;
  logic [31:0]          imm_sx;
  logic [DATA_W-1:0]    rf_rdata_a, rf_rdata_b;
  logic                 rf_we;
  logic                 unused_ir;

  assign opc    = ir[OPC_LSB +: OPC_W];
  assign rd_f   = ir[RD_LSB  +: RA_W];
  assign rs1_f  = ir[RS1_LSB +: RA_W];
  assign rs2_f  = ir[IMM_LSB +: RA_W];
  assign imm    = ir[IMM_LSB +: FIELD_W];
  assign imm_sx = {{24{imm[7]}}, imm};
  assign unused_ir = ^ir;

  // STORE and BEQ need r[rd] on the second read port instead of r[rs2].
  assign rf_raddr_b = ((opc == OP_STORE) || (opc == OP_BEQ)) ? rd_f : rs2_f;
  assign rf_we      = (state == S_WB) && writes_rd(opc);

  reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs1_f),
    .raddr_b (rf_raddr_b),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rd_f),
    .wdata   (res)
  );

  assign imem_addr  = pc;
  assign dmem_addr  = maddr;
  assign dmem_wdata = op_b;

  // ALU result, wrapping modulo 2^DATA_W.
  always_comb begin
    alu = '0;
    case (opc)
      OP_ADD:  alu = op_a + op_b;
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_OR:   alu = op_a | op_b;
      default: alu = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and memory request decode; requests are masked during reset.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = !rst;
        if (imem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = (opc == OP_HALT) ? S_HALTED : S_EXEC;
      S_EXEC:   state_next = is_mem_op(opc) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = !rst;
        dmem_we  = !rst && (opc == OP_STORE);
        if (dmem_ready) state_next = S_WB;
      end
      S_WB:     state_next = S_FETCH;
      S_HALTED: halted = !rst;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath registers: instruction, operands, result, address and pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= '0;
      pc    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      maddr <= '0;
      take  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          op_a <= rf_rdata_a;
          op_b <= rf_rdata_b;
        end
        S_EXEC: begin
          res   <= alu;
          maddr <= DADDR_W'(32'(op_a) + 32'(imm));
          take  <= (op_b == op_a);
        end
        S_MEM:    if (dmem_ready && (opc == OP_LOAD)) res <= dmem_rdata;
        S_WB:     pc <= ((opc == OP_BEQ) && take) ? pc + PC_W'(imm_sx) : pc + PC_W'(1);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Bench for multi_cycle_processor: table-driven ALU vectors plus memory, branch and reset sequences.
module tb_multi_cycle_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [4:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata;
  logic [7:0]  dmem_wdata, dmem_rdata;

  logic [31:0] imem [32];
  logic [7:0]  dmem [32];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;
  int checks = 0, failures = 0;

  int exp_f[$], exp_sa[$], exp_sd[$], fcyc[$], hold_q[$], stab_q[$];
  int dhold = 0;
  bit dstable = 1'b1;
  logic [4:0] cap_addr;
  logic       cap_we;
  logic [7:0] cap_wdata;

  multi_cycle_processor dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_ready = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ready = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !imem_req || imem_ready) icnt <= 0; else icnt <= icnt + 1;
    if (rst || !dmem_req || dmem_ready) dcnt <= 0; else dcnt <= dcnt + 1;
    if (!rst && dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] = dmem_wdata;
  end

  // Scoreboard monitors: fetch addresses, stores and memory-request hold time.
  always @(negedge clk) begin
    if (rst) begin
      dhold = 0;
      dstable = 1'b1;
    end else begin
      if (imem_req && imem_ready) begin
        fcyc.push_back(cyc);
        if (exp_f.size() > 0) begin
          int e;
          e = exp_f.pop_front();
          checks++;
          if (int'(imem_addr) != e) begin
            failures++;
            $display("FAIL fetch_addr: got %0d want %0d", imem_addr, e);
          end
        end
      end
      if (dmem_req && dmem_ready && dmem_we) begin
        checks++;
        if (exp_sa.size() == 0) begin
          failures++;
          $display("FAIL store_unexpected: got addr %0d data %0h want none", dmem_addr, dmem_wdata);
        end else begin
          int ea, ed;
          ea = exp_sa.pop_front();
          ed = exp_sd.pop_front();
          if (int'(dmem_addr) != ea || int'(dmem_wdata) != ed) begin
            failures++;
            $display("FAIL store: got addr %0d data %0h want addr %0d data %0h",
                     dmem_addr, dmem_wdata, ea, ed);
          end
        end
      end
      if (dmem_req) begin
        if (dhold == 0) begin
          cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
        end else if (cap_addr != dmem_addr || cap_we != dmem_we || cap_wdata != dmem_wdata) begin
          dstable = 1'b0;
        end
        dhold++;
        if (dmem_ready) begin
          hold_q.push_back(dhold);
          stab_q.push_back(int'(dstable));
          dhold = 0;
          dstable = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [7:0] rd,
                                      input logic [7:0] rs1, input logic [7:0] imm);
    return {op, 4'h0, rd, rs1, imm};
  endfunction

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = enc(4'hF, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic start_run();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    fcyc.delete(); hold_q.delete(); stab_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_halt(input string nm, input int max);
    int n = 0;
    bit busy = 1'b0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_halted"}, int'(halted), 1);
    repeat (8) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halted) busy = 1'b1;
    end
    check({nm, "_quiet_after_halt"}, int'(busy), 0);
  endtask

  task automatic finish_run(input string nm);
    check({nm, "_pending_fetch"}, exp_f.size(), 0);
    check({nm, "_pending_store"}, exp_sa.size(), 0);
    exp_f.delete(); exp_sa.delete(); exp_sd.delete();
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = 8'h00;
    clear_imem();

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({imem_req, dmem_req, dmem_we, halted}), 0);
    check("reset_pc", int'(imem_addr), 0);

    vecs[0] = '{"add_5_7",    4'h0, 8'd5,   8'd7,   8'd12};
    vecs[1] = '{"sub_3_10",   4'h1, 8'd3,   8'd10,  8'hF9};
    vecs[2] = '{"and",        4'h2, 8'hF0,  8'h3C,  8'h30};
    vecs[3] = '{"or",         4'h3, 8'hA0,  8'h05,  8'hA5};
    vecs[4] = '{"add_wrap",   4'h0, 8'd200, 8'd100, 8'd44};
    vecs[5] = '{"sub_0_1",    4'h1, 8'd0,   8'd1,   8'hFF};
    vecs[6] = '{"nop_op7",    4'h7, 8'd9,   8'd9,   8'd0};

    for (int v = 0; v < 7; v++) begin
      clear_imem();
      imem[0] = enc(4'h4, 8'd2, 8'd0, 8'd16);
      imem[1] = enc(4'h4, 8'd3, 8'd0, 8'd17);
      imem[2] = enc(vecs[v].op, 8'd1, 8'd2, 8'd3);
      imem[3] = enc(4'h5, 8'd1, 8'd0, 8'd20);
      dmem[16] = vecs[v].a;
      dmem[17] = vecs[v].b;
      iwait = (v % 2 == 1) ? 1 : 0;
      dwait = 0;
      for (int k = 0; k < 5; k++) exp_f.push_back(k);
      exp_sa.push_back(20);
      exp_sd.push_back(int'(vecs[v].exp));
      start_run();
      wait_halt(vecs[v].name, 100);
      if (v == 0) begin
        check("lat_load", (fcyc.size() >= 5) ? fcyc[1] - fcyc[0] : -1, 5);
        check("lat_add",  (fcyc.size() >= 5) ? fcyc[3] - fcyc[2] : -1, 4);
      end
      finish_run(vecs[v].name);
    end

    // STORE 0xAB to 4, then LOAD it back with three wait cycles on data memory.
    clear_imem();
    imem[0] = enc(4'h4, 8'd5, 8'd0, 8'd16);
    imem[1] = enc(4'h5, 8'd5, 8'd0, 8'd4);
    imem[2] = enc(4'h4, 8'd6, 8'd0, 8'd4);
    imem[3] = enc(4'h5, 8'd6, 8'd0, 8'd21);
    dmem[16] = 8'hAB; dmem[4] = 8'h00;
    iwait = 0; dwait = 3;
    exp_sa.push_back(4);  exp_sd.push_back(8'hAB);
    exp_sa.push_back(21); exp_sd.push_back(8'hAB);
    start_run();
    wait_halt("ldst", 200);
    check("ldst_hold_len", (hold_q.size() >= 3) ? hold_q[2] : -1, 4);
    check("ldst_hold_stable", (stab_q.size() >= 3) ? stab_q[2] : -1, 1);
    check("ldst_load_latency", (fcyc.size() >= 4) ? fcyc[3] - fcyc[2] : -1, 8);
    finish_run("ldst");

    // BEQ at pc 3 with imm 0xFE, equal operands: loops back to pc 1.
    clear_imem();
    imem[0] = enc(4'h7, 8'd0, 8'd0, 8'd0);
    imem[1] = enc(4'h7, 8'd0, 8'd0, 8'd0);
    imem[2] = enc(4'h7, 8'd0, 8'd0, 8'd0);
    imem[3] = enc(4'h6, 8'd1, 8'd2, 8'hFE);
    dwait = 0;
    exp_f = '{0, 1, 2, 3, 1, 2, 3};
    start_run();
    repeat (40) @(negedge clk);
    check("beq_taken_latency", (fcyc.size() >= 5) ? fcyc[4] - fcyc[3] : -1, 4);
    finish_run("beq_taken");

    // BEQ with unequal operands falls through to pc 4.
    clear_imem();
    imem[0] = enc(4'h4, 8'd2, 8'd0, 8'd16);
    imem[1] = enc(4'h7, 8'd0, 8'd0, 8'd0);
    imem[2] = enc(4'h7, 8'd0, 8'd0, 8'd0);
    imem[3] = enc(4'h6, 8'd1, 8'd2, 8'hFE);
    exp_f = '{0, 1, 2, 3, 4};
    start_run();
    wait_halt("beq_not_taken", 100);
    finish_run("beq_not_taken");

    // Writes to r0 are discarded; storing r0 yields zero.
    clear_imem();
    imem[0] = enc(4'h4, 8'd2, 8'd0, 8'd16);
    imem[1] = enc(4'h0, 8'd0, 8'd2, 8'd2);
    imem[2] = enc(4'h4, 8'd0, 8'd0, 8'd16);
    imem[3] = enc(4'h5, 8'd0, 8'd0, 8'd22);
    exp_sa.push_back(22); exp_sd.push_back(0);
    start_run();
    wait_halt("r0", 100);
    finish_run("r0");

    // Reset during a MEM wait abandons the access and refetches from 0.
    clear_imem();
    imem[0] = enc(4'h4, 8'd2, 8'd0, 8'd16);
    dwait = 10;
    start_run();
    begin
      int n = 0;
      while (!dmem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rst_mem_reached", int'(dmem_req), 1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_dmem_req_drop", int'({dmem_req, dmem_we, imem_req, halted}), 0);
    check("rst_pc_zero", int'(imem_addr), 0);
    repeat (2) @(negedge clk);
    check("rst_no_hold_recorded", hold_q.size(), 0);
    fcyc.delete();
    dwait = 0;
    exp_f = '{0, 1};
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_fetch_req", int'(imem_req), 1);
    check("rst_fetch_addr", int'(imem_addr), 0);
    wait_halt("rst_recover", 100);
    finish_run("rst_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
